// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the elastic pipeline stage registers.
//               Holds the occupancy state encoding. The numeric value of each
//               state equals the number of words held, so a state can be
//               exported directly as a level count.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int LEVEL_W = 2;

    typedef enum logic [LEVEL_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot_reg
// Description : W-bit data register with a load enable and an asynchronous
//               clear. One instance holds one word of an elastic stage.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-high clear (contents -> 0)
//               i_load - capture i_d at the next rising edge
//               i_d    - data in
//               o_q    - registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_slot_reg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Elastic two-entry pipeline register (main + skid slot) with
//               valid/ready handshakes on both sides, synchronous flush and a
//               registered upstream ready. Streams one word per cycle and
//               absorbs one extra word when the consumer stalls, so the
//               producer can observe the stall a cycle late without loss.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               flush     - synchronous discard of all held words
//               in_valid  - upstream word present on in_data
//               in_data   - upstream payload
//               in_ready  - registered; high when a word can be accepted
//               out_valid - main slot holds a word
//               out_data  - main slot payload (flop output)
//               out_ready - downstream consumes out_data this edge
//               level     - occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   level
);

    pipe_state_t  r_state;
    pipe_state_t  w_state_nxt;
    logic         r_in_ready;
    logic         r_out_valid;

    logic         w_xfer_in;
    logic         w_xfer_out;
    logic         w_load_main;
    logic         w_load_skid;
    logic         w_main_from_skid;
    logic [W-1:0] w_main_d;
    logic [W-1:0] w_skid_q;
    logic [W-1:0] w_main_q;

    // Handshakes use the registered flags only, so out_ready never reaches
    // in_ready combinationally.
    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // State, ready and valid flops. The handshake flags are re-derived
    // from the next state so they always agree with the occupancy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and slot load enables
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;

        if (flush) begin
            // Any word offered or consumed this cycle is dropped; slot
            // contents are left stale and become don't-care.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_xfer_in && w_xfer_out) begin
                        w_load_main = 1'b1;
                    end else if (w_xfer_in) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_xfer_out) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the output side moves.
                    if (w_xfer_out) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

    pipe_slot_reg #(.W(W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_main),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_slot_reg #(.W(W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_skid),
        .i_d    (in_data),
        .o_q    (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_main_q;
    assign level     = r_state;

endmodule : pipe_skid_reg
`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Elastic two-entry pipeline register with a valid/ready handshake on both sides, synchronous flush and a registered upstream ready. It sits between RV32I pipeline stages where the consuming stage can stall (e.g. ID→EX under a load-use hazard). It lets the producing stage see a stall one cycle late without losing a word, and it sustains one transfer per cycle when neither side stalls.

## Interface
- W, 32, payload width in bits (instruction/PC/control bundle)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of all held words (branch/jump redirect)
- in_valid  in  1  upstream word present on in_data
- in_data  in  W  upstream payload
- in_ready  out  1  registered; block accepts in_data at this edge when in_valid & in_ready
- out_valid  out  1  main slot holds a word
- out_data  out  W  main slot payload, driven directly from a flop
- out_ready  in  1  downstream consumes out_data at this edge when out_valid & out_ready
- level  out  2  occupancy 0..2, for debug/verification

## Operation
- Two slots: main (drives out_*) and skid. States: EMPTY (0 words), ONE (main only), FULL (main+skid).
- in_ready = 1 in EMPTY/ONE, 0 in FULL. It is held in a flop updated alongside the state, not decoded from out_ready.
- A transfer in = in_valid & in_ready. A transfer out = out_valid & out_ready.
- EMPTY: transfer in → main<=in_data, go to ONE. Otherwise stay.
- ONE, in & out → main<=in_data, stay ONE (streaming).
- ONE, in only → skid<=in_data, go to FULL.
- ONE, out only → go to EMPTY.
- ONE, neither → hold.
- FULL: out → main<=skid, go to ONE. No transfer in is possible. Without out → hold both.
- flush=1 has the highest priority: next state EMPTY, in_ready<=1. Any word offered or consumed in the same cycle is discarded; downstream must ignore a consumption in the flush cycle.
- Order is strictly FIFO; no word is duplicated or dropped except by flush/rst.
- Data flops load only on the listed transitions. Stale payload may remain in an empty slot and is don't-care when not valid.
- level = 0/1/2 for EMPTY/ONE/FULL.

## Timing
- Reset (async, immediate): state EMPTY, out_valid=0, in_ready=1, level=0, out_data=0, skid=0.
- Reset deasserted mid-transfer: the first accepted word is the one presented at the first rising edge with rst low.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N. That is a 1-cycle latency, identical to a plain pipeline register.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall: out_ready dropped at cycle N → at most one further word is accepted (into skid), and in_ready is low after that edge.
- Recovery: out_ready rising in FULL → skid moves to main at that edge, and in_ready is high in the next cycle (1-cycle bubble on the input side only).
- All outputs are flop-driven; there is no combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package/header pipe_pkg: state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2. It is reused by other elastic stage registers.
- One sub-module is natural: pipe_slot_reg #(W): W-bit register with load enable and async clear, instantiated twice (main, skid).
- Next-state, in_ready and load-enable logic live in pipe_skid_reg.

## Test plan
- Reset: assert rst mid-stream with level=2 → out_valid=0, in_ready=1, level=0, out_data=0 immediately, without a clock edge.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive edges → out_data=1,2,3,4 one cycle later each, level stays 1, in_ready stays 1.
- Stall/skid: stream 0xA,0xB,0xC with out_ready dropped when main=0xA → 0xB captured in skid, level=2, in_ready=0, 0xC held upstream. Raise out_ready → outputs 0xA,0xB,0xC in order with no loss or duplication.
- Drain: from FULL with in_valid=0, out_ready=1 for 2 cycles → level 2→1→0, out_valid low after the second edge.
- Flush: with level=2, assert flush together with in_valid=1 and data 0x55 → next cycle level=0, out_valid=0, in_ready=1, and 0x55 never appears.
- Random: random in_valid/out_ready/flush over 10k cycles against a queue model → output sequence matches, level≤2, in_ready==(level!=2) every cycle.
